// File: rtl/memory_turn_sched_if.sv
// Bundles the pulse/switch inputs and the board/score/display outputs of the memory-game turn scheduler.
interface memory_turn_sched_if;
    logic        start_pulse;
    logic        click_pulse;
    logic [3:0]  sel_idx;
    logic [47:0] deck;
    logic [15:0] faceup_mask;
    logic [15:0] removed_mask;
    logic        current_player;
    logic [3:0]  p1_pairs;
    logic [3:0]  p2_pairs;
    logic [3:0]  seconds_left;
    logic        game_over;
    logic [1:0]  winner_code;

    modport master (
        output start_pulse, click_pulse, sel_idx, deck,
        input  faceup_mask, removed_mask, current_player, p1_pairs, p2_pairs,
               seconds_left, game_over, winner_code
    );

    modport slave (
        input  start_pulse, click_pulse, sel_idx, deck,
        output faceup_mask, removed_mask, current_player, p1_pairs, p2_pairs,
               seconds_left, game_over, winner_code
    );
endinterface

// File: rtl/memory_turn_sched.sv
// Two-player memory game turn scheduler: picks, show hold, scoring, per-turn countdown, winner detection.
// Optional macro MEMTURN_MATCH_EXTRA_TURN_EN: a non-final match keeps the current player.
module memory_turn_sched #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned TURN_SECONDS  = 15,
    parameter int unsigned SHOW_TICKS    = 50000000
) (
    input  logic clk,
    input  logic rst,
    memory_turn_sched_if.slave bus
);
    localparam int unsigned TICK_W = $clog2(TICKS_PER_SEC);
    localparam int unsigned SHOW_W = $clog2(SHOW_TICKS + 1);

    typedef enum logic [2:0] {IDLE, PICK1, PICK2, SHOW, RESOLVE, WIN} state_t;

    state_t              state_q, state_d;
    logic [15:0]         faceup_q, faceup_d;
    logic [15:0]         removed_q, removed_d;
    logic                player_q, player_d;
    logic [3:0]          p1_q, p1_d;
    logic [3:0]          p2_q, p2_d;
    logic [3:0]          secs_q, secs_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [SHOW_W-1:0]   show_q, show_d;
    logic [3:0]          first_q, first_d;
    logic [3:0]          second_q, second_d;
    logic                over_q, over_d;
    logic [1:0]          winner_q, winner_d;

    logic        eligible;
    logic        is_match;
    logic [5:0]  base_a;
    logic [5:0]  base_b;
    logic [4:0]  total;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            faceup_q <= '0;
            removed_q <= '0;
            player_q <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            secs_q   <= 4'(TURN_SECONDS);
            tick_q   <= '0;
            show_q   <= '0;
            first_q  <= '0;
            second_q <= '0;
            over_q   <= 1'b0;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            faceup_q <= faceup_d;
            removed_q <= removed_d;
            player_q <= player_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            secs_q   <= secs_d;
            tick_q   <= tick_d;
            show_q   <= show_d;
            first_q  <= first_d;
            second_q <= second_d;
            over_q   <= over_d;
            winner_q <= winner_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d  = state_q;
        faceup_d = faceup_q;
        removed_d = removed_q;
        player_d = player_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        secs_d   = secs_q;
        tick_d   = tick_q;
        show_d   = show_q;
        first_d  = first_q;
        second_d = second_q;
        over_d   = over_q;
        winner_d = winner_q;
        total    = '0;

        eligible = !removed_q[bus.sel_idx] &&
                   !((state_q == PICK2) && (bus.sel_idx == first_q));
        base_a   = 6'(first_q) * 6'd3;
        base_b   = 6'(second_q) * 6'd3;
        is_match = (bus.deck[base_a +: 3] == bus.deck[base_b +: 3]);

        case (state_q)
            IDLE, WIN: begin
                if (bus.start_pulse) begin
                    state_d   = PICK1;
                    faceup_d  = '0;
                    removed_d = '0;
                    player_d  = 1'b0;
                    p1_d      = '0;
                    p2_d      = '0;
                    secs_d    = 4'(TURN_SECONDS);
                    tick_d    = '0;
                    over_d    = 1'b0;
                    winner_d  = '0;
                end
            end
            PICK1, PICK2: begin
                if (secs_q == 4'd0) begin
                    // Timeout forfeits the turn and drops any same-cycle click
                    state_d  = PICK1;
                    faceup_d = '0;
                    player_d = ~player_q;
                    secs_d   = 4'(TURN_SECONDS);
                    tick_d   = '0;
                end else begin
                    if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
                        tick_d = '0;
                        secs_d = secs_q - 4'd1;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                    if (bus.click_pulse && eligible) begin
                        faceup_d = faceup_q | (16'(1) << bus.sel_idx);
                        if (state_q == PICK1) begin
                            first_d = bus.sel_idx;
                            state_d = PICK2;
                        end else begin
                            second_d = bus.sel_idx;
                            show_d   = '0;
                            state_d  = SHOW;
                        end
                    end
                end
            end
            SHOW: begin
                if (show_q == SHOW_W'(SHOW_TICKS - 1)) begin
                    state_d = RESOLVE;
                end else begin
                    show_d = show_q + SHOW_W'(1);
                end
            end
            RESOLVE: begin
                faceup_d = '0;
                if (is_match) begin
                    removed_d = removed_q | (16'(1) << first_q) | (16'(1) << second_q);
                    if (player_q) p2_d = p2_q + 4'd1;
                    else          p1_d = p1_q + 4'd1;
                end
                total = 5'(p1_d) + 5'(p2_d);
                if (total == 5'd8) begin
                    state_d   = WIN;
                    over_d    = 1'b1;
                    removed_d = '1;
                    if (p1_d > p2_d)      winner_d = 2'd1;
                    else if (p2_d > p1_d) winner_d = 2'd2;
                    else                  winner_d = 2'd3;
                end else begin
                    state_d = PICK1;
`ifdef MEMTURN_MATCH_EXTRA_TURN_EN
                    player_d = is_match ? player_q : ~player_q;
`else
                    player_d = ~player_q;
`endif
                    secs_d = 4'(TURN_SECONDS);
                    tick_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.faceup_mask    = faceup_q;
    assign bus.removed_mask   = removed_q;
    assign bus.current_player = player_q;
    assign bus.p1_pairs       = p1_q;
    assign bus.p2_pairs       = p2_q;
    assign bus.seconds_left   = secs_q;
    assign bus.game_over      = over_q;
    assign bus.winner_code    = winner_q;
endmodule

// File: tb/tb_memory_turn_sched.sv
// Directed self-checking bench for memory_turn_sched with a small timing configuration.
module tb_memory_turn_sched;
`ifdef MEMTURN_MATCH_EXTRA_TURN_EN
    localparam bit EXTRA = 1'b1;
`else
    localparam bit EXTRA = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    memory_turn_sched_if bus ();

    memory_turn_sched #(
        .TICKS_PER_SEC(4),
        .TURN_SECONDS (3),
        .SHOW_TICKS   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: called just after a negedge, return just after the next negedge
    task automatic click(input logic [3:0] idx);
        bus.sel_idx = idx;
        bus.click_pulse = 1'b1;
        @(negedge clk);
        bus.click_pulse = 1'b0;
    endtask

    task automatic start();
        bus.start_pulse = 1'b1;
        @(negedge clk);
        bus.start_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        start();
        click(4'd0);
        click(4'd1);
        tests++; if (bus.faceup_mask !== 16'h0003) begin fails++; $display("FAIL reset_pre_faceup got %h want %h", bus.faceup_mask, 16'h0003); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.faceup_mask !== 16'h0000) begin fails++; $display("FAIL reset_faceup got %h want %h", bus.faceup_mask, 16'h0000); end
        tests++; if (bus.removed_mask !== 16'h0000) begin fails++; $display("FAIL reset_removed got %h want %h", bus.removed_mask, 16'h0000); end
        tests++; if (bus.p1_pairs !== 4'd0 || bus.p2_pairs !== 4'd0) begin fails++; $display("FAIL reset_pairs got %0d/%0d want 0/0", bus.p1_pairs, bus.p2_pairs); end
        tests++; if (bus.seconds_left !== 4'd3) begin fails++; $display("FAIL reset_secs got %0d want 3", bus.seconds_left); end
        tests++; if (bus.game_over !== 1'b0 || bus.winner_code !== 2'd0 || bus.current_player !== 1'b0) begin fails++; $display("FAIL reset_flags got go=%b wc=%0d pl=%b want 0/0/0", bus.game_over, bus.winner_code, bus.current_player); end
        @(negedge clk);
        rst = 1'b0;
        // IDLE ignores clicks
        click(4'd4);
        tests++; if (bus.faceup_mask !== 16'h0000) begin fails++; $display("FAIL idle_click got %h want %h", bus.faceup_mask, 16'h0000); end
    endtask

    task automatic test_match();
        do_reset();
        start();
        click(4'd0);
        tests++; if (bus.faceup_mask !== 16'h0001) begin fails++; $display("FAIL match_pick1 got %h want %h", bus.faceup_mask, 16'h0001); end
        click(4'd1);
        tests++; if (bus.faceup_mask !== 16'h0003) begin fails++; $display("FAIL match_show0 got %h want %h", bus.faceup_mask, 16'h0003); end
        // clicks and start are ignored while showing
        bus.start_pulse = 1'b1;
        click(4'd5);
        bus.start_pulse = 1'b0;
        tests++; if (bus.faceup_mask !== 16'h0003) begin fails++; $display("FAIL match_show1 got %h want %h", bus.faceup_mask, 16'h0003); end
        tests++; if (bus.removed_mask !== 16'h0000) begin fails++; $display("FAIL match_not_yet got %h want %h", bus.removed_mask, 16'h0000); end
        idle(2);
        tests++; if (bus.removed_mask !== 16'h0003 || bus.faceup_mask !== 16'h0000) begin fails++; $display("FAIL match_resolve got rm=%h fu=%h want 0003/0000", bus.removed_mask, bus.faceup_mask); end
        tests++; if (bus.p1_pairs !== 4'd1 || bus.p2_pairs !== 4'd0) begin fails++; $display("FAIL match_pairs got %0d/%0d want 1/0", bus.p1_pairs, bus.p2_pairs); end
        tests++; if (bus.current_player !== !EXTRA) begin fails++; $display("FAIL match_player got %b want %b", bus.current_player, !EXTRA); end
        tests++; if (bus.seconds_left !== 4'd3) begin fails++; $display("FAIL match_secs got %0d want 3", bus.seconds_left); end
    endtask

    task automatic test_mismatch();
        do_reset();
        start();
        click(4'd0);
        click(4'd2);
        idle(3);
        tests++; if (bus.faceup_mask !== 16'h0000 || bus.removed_mask !== 16'h0000) begin fails++; $display("FAIL mis_masks got fu=%h rm=%h want 0/0", bus.faceup_mask, bus.removed_mask); end
        tests++; if (bus.current_player !== 1'b1 || bus.p1_pairs !== 4'd0) begin fails++; $display("FAIL mis_player got pl=%b p1=%0d want 1/0", bus.current_player, bus.p1_pairs); end
        click(4'd0);
        click(4'd1);
        idle(3);
        tests++; if (bus.p2_pairs !== 4'd1 || bus.removed_mask !== 16'h0003) begin fails++; $display("FAIL mis_p2match got p2=%0d rm=%h want 1/0003", bus.p2_pairs, bus.removed_mask); end
        click(4'd0);
        tests++; if (bus.faceup_mask !== 16'h0000) begin fails++; $display("FAIL removed_click got %h want %h", bus.faceup_mask, 16'h0000); end
        click(4'd2);
        tests++; if (bus.faceup_mask !== 16'h0004) begin fails++; $display("FAIL after_removed got %h want %h", bus.faceup_mask, 16'h0004); end
    endtask

    task automatic test_timeout();
        do_reset();
        start();
        idle(4);
        tests++; if (bus.seconds_left !== 4'd2) begin fails++; $display("FAIL tmo_sec2 got %0d want 2", bus.seconds_left); end
        idle(4);
        tests++; if (bus.seconds_left !== 4'd1) begin fails++; $display("FAIL tmo_sec1 got %0d want 1", bus.seconds_left); end
        idle(4);
        tests++; if (bus.seconds_left !== 4'd0 || bus.current_player !== 1'b0) begin fails++; $display("FAIL tmo_sec0 got s=%0d pl=%b want 0/0", bus.seconds_left, bus.current_player); end
        click(4'd5);
        tests++; if (bus.current_player !== 1'b1 || bus.seconds_left !== 4'd3) begin fails++; $display("FAIL tmo_switch got pl=%b s=%0d want 1/3", bus.current_player, bus.seconds_left); end
        tests++; if (bus.faceup_mask !== 16'h0000) begin fails++; $display("FAIL tmo_click_drop got %h want %h", bus.faceup_mask, 16'h0000); end
        click(4'd5);
        tests++; if (bus.faceup_mask !== 16'h0020) begin fails++; $display("FAIL tmo_pick1 got %h want %h", bus.faceup_mask, 16'h0020); end
    endtask

    task automatic test_same_index();
        do_reset();
        start();
        click(4'd3);
        click(4'd3);
        tests++; if (bus.faceup_mask !== 16'h0008) begin fails++; $display("FAIL same_idx got %h want %h", bus.faceup_mask, 16'h0008); end
        click(4'd2);
        tests++; if (bus.faceup_mask !== 16'h000C) begin fails++; $display("FAIL same_idx_pick2 got %h want %h", bus.faceup_mask, 16'h000C); end
    endtask

    task automatic test_full_game();
        do_reset();
        start();
        for (int k = 0; k < 8; k++) begin
            if (EXTRA && k == 4) begin
                click(4'd8);
                click(4'd10);
                idle(3);
            end
            click(4'(2 * k));
            click(4'(2 * k + 1));
            idle(3);
        end
        tests++; if (bus.game_over !== 1'b1 || bus.winner_code !== 2'd3) begin fails++; $display("FAIL win_flags got go=%b wc=%0d want 1/3", bus.game_over, bus.winner_code); end
        tests++; if (bus.removed_mask !== 16'hFFFF || bus.faceup_mask !== 16'h0000) begin fails++; $display("FAIL win_masks got rm=%h fu=%h want ffff/0000", bus.removed_mask, bus.faceup_mask); end
        tests++; if (bus.p1_pairs !== 4'd4 || bus.p2_pairs !== 4'd4) begin fails++; $display("FAIL win_pairs got %0d/%0d want 4/4", bus.p1_pairs, bus.p2_pairs); end
        idle(2);
        tests++; if (bus.game_over !== 1'b1) begin fails++; $display("FAIL win_hold got %b want 1", bus.game_over); end
        start();
        tests++; if (bus.game_over !== 1'b0 || bus.winner_code !== 2'd0 || bus.removed_mask !== 16'h0000) begin fails++; $display("FAIL restart got go=%b wc=%0d rm=%h want 0/0/0", bus.game_over, bus.winner_code, bus.removed_mask); end
        tests++; if (bus.current_player !== 1'b0 || bus.p1_pairs !== 4'd0 || bus.p2_pairs !== 4'd0 || bus.seconds_left !== 4'd3) begin fails++; $display("FAIL restart_regs got pl=%b p=%0d/%0d s=%0d want 0 0/0 3", bus.current_player, bus.p1_pairs, bus.p2_pairs, bus.seconds_left); end
        click(4'd0);
        tests++; if (bus.faceup_mask !== 16'h0001) begin fails++; $display("FAIL restart_pick got %h want %h", bus.faceup_mask, 16'h0001); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.start_pulse = 1'b0;
        bus.click_pulse = 1'b0;
        bus.sel_idx = 4'd0;
        for (int i = 0; i < 16; i++) bus.deck[3*i +: 3] = 3'(i >> 1);
        @(negedge clk);
        test_reset();
        test_match();
        test_mismatch();
        test_timeout();
        test_same_index();
        test_full_game();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/memory_turn_sched.md
Name: memory_turn_sched

Overview:
Turn scheduler for the two-player memory game: sequences start, two card picks per turn, mismatch display hold, scoring, per-turn countdown with timeout forfeit, and winner detection. Sits between the debounced START/CLICK pulses and switch index on one side, and the VGA video generator, turn LEDs and 7-segment displays on the other. It owns the faceup/removed board masks and both score counters.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per countdown second (>=2)
TURN_SECONDS, 15, countdown reload value per turn (1..15)
SHOW_TICKS, 50000000, clk cycles both picked cards stay face up before resolve (>=1)

Ports:
clk  in  1  system clock (50 MHz domain)
rst  in  1  asynchronous reset, active-high
start_pulse  in  1  one-cycle debounced START
click_pulse  in  1  one-cycle debounced CLICK
sel_idx  in  4  card index from switches
deck  in  48  pair id of card i at deck[3*i+:3]; each id 0..7 appears exactly twice, static during a game
faceup_mask  out  16  bit i = card i shown face up
removed_mask  out  16  bit i = card i matched and removed
current_player  out  1  0 = P1, 1 = P2
p1_pairs  out  4  P1 matched pairs (0..8)
p2_pairs  out  4  P2 matched pairs (0..8)
seconds_left  out  4  turn countdown
game_over  out  1  high in WIN
winner_code  out  2  0 none, 1 P1, 2 P2, 3 tie (valid in WIN)

Behaviour:
- Reset (async, any state): state IDLE; masks 0; current_player 0; pairs 0; seconds_left = TURN_SECONDS; tick and show counters 0; game_over 0; winner_code 0.
- States: IDLE, PICK1, PICK2, SHOW, RESOLVE, WIN. All outputs registered.
- IDLE: start_pulse -> PICK1; clears masks and pairs, player 0, seconds reload, tick counter 0.
- Eligible card: removed_mask[sel_idx]==0 and, in PICK2, sel_idx != first pick.
- PICK1: click_pulse on eligible card -> faceup bit set next edge, index latched as first, go PICK2. Ineligible click ignored, no state change.
- PICK2: eligible click -> faceup bit set, index latched as second, go SHOW, show counter 0.
- SHOW: count SHOW_TICKS cycles (timer frozen, clicks/start ignored), then RESOLVE.
- RESOLVE (1 cycle): pair ids equal -> both removed bits set, faceup cleared, current player's pair count +1; different -> faceup cleared only. Then: if total pairs after update == 8 -> WIN; else switch current_player, reload seconds_left, clear tick counter, go PICK1.
- Countdown: runs only in PICK1/PICK2. Tick counter wraps at TICKS_PER_SEC-1; on wrap seconds_left decrements, saturating at 0.
- Timeout: in PICK1/PICK2 with seconds_left==0 -> next edge clear faceup, switch player, reload seconds, tick counter 0, go PICK1. Timeout has priority over a same-cycle click_pulse (click dropped).
- WIN: game_over=1; winner_code = 1 if p1>p2, 2 if p2>p1, 3 if equal; faceup 0, removed all 1. start_pulse -> same action as from IDLE (new game, game_over/winner_code cleared).
- start_pulse outside IDLE/WIN ignored; only rst or WIN+start restarts a game.
- Pair counters never exceed 8; no wrap possible with valid decks.

Optional Feature:
MEMTURN_MATCH_EXTRA_TURN_EN: when defined, a match in RESOLVE that does not end the game keeps current_player unchanged (seconds still reloaded). When undefined, every non-final RESOLVE switches player, matched or not.

Test Plan:
Params TICKS_PER_SEC=4, TURN_SECONDS=3, SHOW_TICKS=2; deck id(i)=i>>1 (pairs 0/1, 2/3, ...).
Reset mid-SHOW with cards 0,1 face up -> same cycle faceup_mask=0, pairs 0, seconds_left=3, state IDLE; start ignored path not needed.
Start, click 0, click 1 -> faceup 0x0003 for 2 cycles, then removed 0x0003, p1_pairs=1, current_player=1 (0 with macro), seconds_left=3.
Start, click 0, click 2 -> resolve mismatch: faceup 0, removed 0, player 1; click on removed card 0 after a match -> no change.
PICK1 idle 12 cycles -> seconds_left 3->2->1->0, next cycle player toggles, seconds_left=3; click on timeout cycle dropped.
PICK2 click same index as first -> ignored, stays PICK2 with single faceup bit.
Play all 8 pairs, P1 4 and P2 4 -> game_over=1, winner_code=3, removed 0xFFFF; start_pulse -> all cleared, PICK1, player 0.
